uart_receiver: RTL and testbench

Receive-side companion to `uart_transmitter` in the ice40 uncore: samples an asynchronous 8N1 serial line and produces one parallel byte per frame with a single-cycle valid strobe. It sits between the board RX pin and the host-command logic, and it loops back directly against `uart_transmitter`'s `tx_out` in benches. It reports framing errors and rejects start-bit glitches shorter than half a baud.

---
 rtl/uart_receiver.sv | 141 ++++++++++++++
 tb/tb_uart_receiver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - 8N1 UART receiver with start-glitch rejection and framing-error pulse.
// Optional two-flop input synchronizer enabled by defining UART_RX_SYNC_EN.
module uart_receiver #(
  parameter int ClocksPerBaud = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_byte_out,
  output logic       rx_byte_valid_out,
  output logic       rx_framing_error_out,
  output logic       rx_busy_out
);

  localparam int H  = ClocksPerBaud / 2;
  localparam int CW = (ClocksPerBaud > 1) ? $clog2(ClocksPerBaud) : 1;
  localparam logic [CW-1:0] HALF_LAST = CW'(H - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(ClocksPerBaud - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BRK
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [7:0]    byte_n;
  logic          valid_n;
  logic          err_n;
  logic          rx_s;

`ifdef UART_RX_SYNC_EN
  logic [1:0] sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= 2'b11;
    end else begin
      sync <= {sync[0], rx};
    end
  end

  assign rx_s = sync[1];
`else
  assign rx_s = rx;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= IDLE;
      cnt                  <= '0;
      bit_idx              <= '0;
      shift                <= '0;
      rx_byte_out          <= 8'h00;
      rx_byte_valid_out    <= 1'b0;
      rx_framing_error_out <= 1'b0;
    end else begin
      state                <= state_n;
      cnt                  <= cnt_n;
      bit_idx              <= bit_idx_n;
      shift                <= shift_n;
      rx_byte_out          <= byte_n;
      rx_byte_valid_out    <= valid_n;
      rx_framing_error_out <= err_n;
    end
  end

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    byte_n    = rx_byte_out;
    valid_n   = 1'b0;
    err_n     = 1'b0;
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt == HALF_LAST) begin
          if (rx_s) begin
            state_n = IDLE;
          end else begin
            state_n   = DATA;
            cnt_n     = '0;
            bit_idx_n = '0;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BAUD_LAST) begin
          shift_n   = {rx_s, shift[7:1]};
          cnt_n     = '0;
          bit_idx_n = bit_idx + 3'd1;
          if (bit_idx == 3'd7) begin
            state_n = STOP;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      STOP: begin
        // Leave at mid-stop-bit so a back-to-back start edge is caught at once.
        if (cnt == BAUD_LAST) begin
          cnt_n = '0;
          if (rx_s) begin
            byte_n  = shift;
            valid_n = 1'b1;
            state_n = IDLE;
          end else begin
            err_n   = 1'b1;
            state_n = BRK;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      BRK: begin
        if (rx_s) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign rx_busy_out = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - randomized and directed bench for uart_receiver against a frame-timing model.
module tb_uart_receiver;

  localparam int CPB = 4;
  localparam int H   = CPB / 2;
`ifdef UART_RX_SYNC_EN
  localparam int SYNC_LAT = 2;
`else
  localparam int SYNC_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b0;
  logic [7:0] rx_byte_out;
  logic       rx_byte_valid_out;
  logic       rx_framing_error_out;
  logic       rx_busy_out;

  int vectors     = 0;
  int miscompares = 0;

  uart_receiver #(.ClocksPerBaud(CPB)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .rx                  (rx),
    .rx_byte_out         (rx_byte_out),
    .rx_byte_valid_out   (rx_byte_valid_out),
    .rx_framing_error_out(rx_framing_error_out),
    .rx_busy_out         (rx_busy_out)
  );

  always #5 clk = ~clk;

  // Model: frame events are placed by offset from the first low edge E.
  int         cyc = 0;
  int         m_mode = 0;
  int         m_e = 0;
  logic [7:0] m_bits = '0;
  logic [7:0] m_byte = '0;
  logic       m_valid = 1'b0;
  logic       m_err = 1'b0;
  logic       m_busy = 1'b0;
  logic       m_d1 = 1'b1;
  logic       m_d2 = 1'b1;
  int         m_err_cnt = 0;
  int         valid_q[$];
  logic [7:0] byte_q[$];

  always @(posedge clk) begin
    logic rs;
    int   off;
    int   n;
    if (rst) begin
      m_mode = 0; m_byte = '0; m_valid = 1'b0; m_err = 1'b0;
      m_d1 = 1'b1; m_d2 = 1'b1;
    end else begin
      rs = (SYNC_LAT != 0) ? m_d2 : rx;
      m_d2 = m_d1;
      m_d1 = rx;
      m_valid = 1'b0;
      m_err   = 1'b0;
      if (m_mode == 0) begin
        if (!rs) begin
          m_mode = 1;
          m_e    = cyc;
        end
      end else if (m_mode == 1) begin
        off = cyc - m_e;
        if (off == H) begin
          if (rs) m_mode = 0;
        end else if (off > H && (off - H) % CPB == 0) begin
          n = (off - H) / CPB;
          if (n <= 8) begin
            m_bits[n-1] = rs;
          end else if (rs) begin
            m_byte  = m_bits;
            m_valid = 1'b1;
            m_mode  = 0;
            valid_q.push_back(cyc);
            byte_q.push_back(m_bits);
          end else begin
            m_err  = 1'b1;
            m_mode = 2;
            m_err_cnt++;
          end
        end
      end else begin
        if (rs) m_mode = 0;
      end
    end
    m_busy = (m_mode != 0);
    cyc++;
  end

  always @(negedge clk) begin
    vectors++;
    if (rx_byte_out !== m_byte || rx_byte_valid_out !== m_valid ||
        rx_framing_error_out !== m_err || rx_busy_out !== m_busy) begin
      miscompares++;
      $display("FAIL cycle_compare @%0d: got byte=%h valid=%b err=%b busy=%b expected byte=%h valid=%b err=%b busy=%b",
               cyc, rx_byte_out, rx_byte_valid_out, rx_framing_error_out, rx_busy_out,
               m_byte, m_valid, m_err, m_busy);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    rx = lvl;
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input logic stop);
    drive(1'b0, CPB);
    for (int i = 0; i < 8; i++) drive(b[i], CPB);
    drive(stop, CPB);
  endtask

  initial begin
    int n0;
    int e0;
    int first_low;
    int bc;
    int hold;
    logic [7:0] rb;

    // Reset held with the line low
    rst = 1'b1; rx = 1'b0;
    repeat (6) begin
      @(negedge clk);
      check("reset_busy", rx_busy_out, 0);
    end
    check("reset_byte", rx_byte_out, 0);
    rst = 1'b0;
    drive(1'b1, 4);

    // Single frame A5
    n0 = valid_q.size();
    first_low = cyc;
    send(8'hA5, 1'b1);
    drive(1'b1, 6);
    check("a5_count", valid_q.size() - n0, 1);
    check("a5_latency", valid_q[$] - first_low, 38 + SYNC_LAT);
    check("a5_byte", byte_q[$], 8'hA5);

    // Back-to-back 55, AA
    n0 = valid_q.size();
    e0 = m_err_cnt;
    send(8'h55, 1'b1);
    send(8'hAA, 1'b1);
    drive(1'b1, 10);
    check("b2b_count", valid_q.size() - n0, 2);
    check("b2b_first", byte_q[n0], 8'h55);
    check("b2b_second", byte_q[n0+1], 8'hAA);
    check("b2b_spacing", valid_q[n0+1] - valid_q[n0], 10 * CPB);
    check("b2b_no_err", m_err_cnt - e0, 0);

    // Start-bit glitch shorter than half a baud
    n0 = valid_q.size();
    e0 = m_err_cnt;
    bc = 0;
    rx = 1'b0;
    @(negedge clk);
    bc += int'(m_busy);
    rx = 1'b1;
    repeat (10) begin
      @(negedge clk);
      bc += int'(m_busy);
    end
    check("glitch_busy_cycles", bc, 2);
    check("glitch_no_valid", valid_q.size() - n0, 0);
    check("glitch_no_err", m_err_cnt - e0, 0);

    // Framing error with held-low line
    n0 = valid_q.size();
    e0 = m_err_cnt;
    send(8'h3C, 1'b0);
    drive(1'b0, 30);
    drive(1'b1, 8);
    check("ferr_pulses", m_err_cnt - e0, 1);
    check("ferr_no_valid", valid_q.size() - n0, 0);
    check("ferr_byte_kept", m_byte, 8'hAA);
    send(8'h01, 1'b1);
    drive(1'b1, 6);
    check("ferr_next_byte", byte_q[$], 8'h01);

    // Reset in the middle of a frame
    n0 = valid_q.size();
    drive(1'b0, CPB);
    drive(1'b1, 4 * CPB + 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 5 * CPB + 4);
    check("midrst_no_valid", valid_q.size() - n0, 0);
    check("midrst_byte_cleared", m_byte, 8'h00);
    send(8'h12, 1'b1);
    drive(1'b1, 6);
    check("midrst_next_byte", byte_q[$], 8'h12);

    // Random traffic: frames, bad stop bits, glitches, variable gaps
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 9))
        0: begin
          drive(1'b0, $urandom_range(1, CPB));
          drive(1'b1, $urandom_range(1, 6));
        end
        1: begin
          rb = 8'($urandom);
          send(rb, 1'b0);
          hold = $urandom_range(0, 12);
          if (hold > 0) drive(1'b0, hold);
          drive(1'b1, $urandom_range(0, 5));
        end
        default: begin
          rb = 8'($urandom);
          send(rb, 1'b1);
          drive(1'b1, $urandom_range(0, 5));
        end
      endcase
    end
    drive(1'b1, 60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
